// File: rtl/ps2_pkg.sv
// Shared scan-code-set-2 constants and decoder state encoding for the PS/2 keyboard path.
package ps2_pkg;

    // Prefix bytes that open multi-byte sequences
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    // Modifier make codes (right ctrl is SC_CTRL behind an E0 prefix)
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Keyboard responses that never form part of a key sequence
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_ECHO    = 8'hEE;
    localparam logic [7:0] SC_RESEND  = 8'hFE;
    localparam logic [7:0] SC_OVRUN0  = 8'h00;
    localparam logic [7:0] SC_OVRUN1  = 8'hFF;

    // Bytes following E1 in the Pause sequence (E1 14 77 E1 F0 14 F0 77)
    localparam logic [2:0] E1_SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_SKIP_E1
    } dec_state_t;

    function automatic logic is_response(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_ECHO) ||
               (b == SC_RESEND) || (b == SC_OVRUN0) || (b == SC_OVRUN1);
    endfunction

endpackage

// File: rtl/ps2_set2_to_ascii.sv
// Combinational scan-code-set-2 make code to US-layout ASCII lookup.
module ps2_set2_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    input  logic       ctrl,
    output logic [7:0] ascii,
    output logic       hit
);

    logic [7:0] lo;
    logic [7:0] hi;
    logic       letter;

    // Table lookup: lo is the unshifted character, hi the shifted one
    always_comb begin
        lo     = 8'h00;
        hi     = 8'h00;
        letter = 1'b0;
        hit    = 1'b1;
        case (code)
            8'h1C: begin lo = 8'h61; letter = 1'b1; end
            8'h32: begin lo = 8'h62; letter = 1'b1; end
            8'h21: begin lo = 8'h63; letter = 1'b1; end
            8'h23: begin lo = 8'h64; letter = 1'b1; end
            8'h24: begin lo = 8'h65; letter = 1'b1; end
            8'h2B: begin lo = 8'h66; letter = 1'b1; end
            8'h34: begin lo = 8'h67; letter = 1'b1; end
            8'h33: begin lo = 8'h68; letter = 1'b1; end
            8'h43: begin lo = 8'h69; letter = 1'b1; end
            8'h3B: begin lo = 8'h6A; letter = 1'b1; end
            8'h42: begin lo = 8'h6B; letter = 1'b1; end
            8'h4B: begin lo = 8'h6C; letter = 1'b1; end
            8'h3A: begin lo = 8'h6D; letter = 1'b1; end
            8'h31: begin lo = 8'h6E; letter = 1'b1; end
            8'h44: begin lo = 8'h6F; letter = 1'b1; end
            8'h4D: begin lo = 8'h70; letter = 1'b1; end
            8'h15: begin lo = 8'h71; letter = 1'b1; end
            8'h2D: begin lo = 8'h72; letter = 1'b1; end
            8'h1B: begin lo = 8'h73; letter = 1'b1; end
            8'h2C: begin lo = 8'h74; letter = 1'b1; end
            8'h3C: begin lo = 8'h75; letter = 1'b1; end
            8'h2A: begin lo = 8'h76; letter = 1'b1; end
            8'h1D: begin lo = 8'h77; letter = 1'b1; end
            8'h22: begin lo = 8'h78; letter = 1'b1; end
            8'h35: begin lo = 8'h79; letter = 1'b1; end
            8'h1A: begin lo = 8'h7A; letter = 1'b1; end
            8'h45: begin lo = 8'h30; hi = 8'h29; end
            8'h16: begin lo = 8'h31; hi = 8'h21; end
            8'h1E: begin lo = 8'h32; hi = 8'h40; end
            8'h26: begin lo = 8'h33; hi = 8'h23; end
            8'h25: begin lo = 8'h34; hi = 8'h24; end
            8'h2E: begin lo = 8'h35; hi = 8'h25; end
            8'h36: begin lo = 8'h36; hi = 8'h5E; end
            8'h3D: begin lo = 8'h37; hi = 8'h26; end
            8'h3E: begin lo = 8'h38; hi = 8'h2A; end
            8'h46: begin lo = 8'h39; hi = 8'h28; end
            8'h0E: begin lo = 8'h60; hi = 8'h7E; end
            8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
            8'h55: begin lo = 8'h3D; hi = 8'h2B; end
            8'h54: begin lo = 8'h5B; hi = 8'h7B; end
            8'h5B: begin lo = 8'h5D; hi = 8'h7D; end
            8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
            8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
            8'h52: begin lo = 8'h27; hi = 8'h22; end
            8'h41: begin lo = 8'h2C; hi = 8'h3C; end
            8'h49: begin lo = 8'h2E; hi = 8'h3E; end
            8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
            8'h29: begin lo = 8'h20; hi = 8'h20; end
            8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
            8'h66: begin lo = 8'h08; hi = 8'h08; end
            8'h76: begin lo = 8'h1B; hi = 8'h1B; end
            8'h0D: begin lo = 8'h09; hi = 8'h09; end
            default: hit = 1'b0;
        endcase
    end

    // Case selection: caps only affects letters, ctrl folds letters to control codes
    always_comb begin
        if (letter) begin
            ascii = (shift ^ caps) ? (lo & 8'hDF) : lo;
            if (ctrl) ascii = ascii & 8'h1F;
        end else begin
            ascii = shift ? hi : lo;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code-set-2 sequence decoder with modifier tracking and an ASCII output FIFO.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_error,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       shift,
    output logic       ctrl,
    output logic       caps_lock,
    output logic [7:0] out_ascii,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    dec_state_t state, state_nx;
    logic [2:0] skip_count, skip_nx;
    logic       emit, emit_ext, emit_rel;

    logic lshift_held, rshift_held, lctrl_held, rctrl_held, caps_held;

    logic [7:0] lut_ascii;
    logic       lut_hit;
    logic       push_req, push_ok, pop, full;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    // Sequence state register
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            skip_count <= 3'd0;
        end else begin
            state      <= state_nx;
            skip_count <= skip_nx;
        end
    end

    // Next-state: prefixes advance, a receiver error abandons any partial sequence
    always_comb begin
        state_nx = state;
        skip_nx  = skip_count;
        if (in_error) begin
            state_nx = ST_IDLE;
            skip_nx  = 3'd0;
        end else if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    if (in_data == SC_E0)      state_nx = ST_E0;
                    else if (in_data == SC_F0) state_nx = ST_F0;
                    else if (in_data == SC_E1) begin
                        state_nx = ST_SKIP_E1;
                        skip_nx  = E1_SKIP_LEN;
                    end
                end
                ST_E0:      state_nx = (in_data == SC_F0) ? ST_E0F0 : ST_IDLE;
                ST_F0:      state_nx = ST_IDLE;
                ST_E0F0:    state_nx = ST_IDLE;
                ST_SKIP_E1: begin
                    skip_nx = skip_count - 3'd1;
                    if (skip_count <= 3'd1) state_nx = ST_IDLE;
                end
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    // Event outputs: which byte completes a key sequence, and with which prefixes
    always_comb begin
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_rel = 1'b0;
        if (in_valid && !in_error) begin
            case (state)
                ST_IDLE: emit = (in_data != SC_E0) && (in_data != SC_F0) &&
                                (in_data != SC_E1) && !is_response(in_data);
                ST_E0: begin
                    emit     = (in_data != SC_F0) && (in_data != SC_LSHIFT);
                    emit_ext = 1'b1;
                end
                ST_F0: begin
                    emit     = 1'b1;
                    emit_rel = 1'b1;
                end
                ST_E0F0: begin
                    emit     = (in_data != SC_LSHIFT);
                    emit_ext = 1'b1;
                    emit_rel = 1'b1;
                end
                default: emit = 1'b0;
            endcase
        end
    end

    // Key event register: fields hold until the next completed sequence
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            key_event    <= 1'b0;
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_release  <= 1'b0;
        end else begin
            key_event <= emit;
            if (emit) begin
                key_code     <= in_data;
                key_extended <= emit_ext;
                key_release  <= emit_rel;
            end
        end
    end

    // Modifier tracking, updated alongside the event so the next key sees it
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            lctrl_held  <= 1'b0;
            rctrl_held  <= 1'b0;
            caps_held   <= 1'b0;
            caps_lock   <= 1'b0;
        end else if (emit) begin
            if (!emit_ext && in_data == SC_LSHIFT) lshift_held <= !emit_rel;
            if (!emit_ext && in_data == SC_RSHIFT) rshift_held <= !emit_rel;
            if (!emit_ext && in_data == SC_CTRL)   lctrl_held  <= !emit_rel;
            if (emit_ext && in_data == SC_CTRL)    rctrl_held  <= !emit_rel;
            if (!emit_ext && in_data == SC_CAPS) begin
                if (emit_rel) begin
                    caps_held <= 1'b0;
                end else if (!caps_held) begin
                    caps_lock <= !caps_lock;
                    caps_held <= 1'b1;
                end
            end
        end
    end

    assign shift = lshift_held | rshift_held;
    assign ctrl  = lctrl_held | rctrl_held;

    ps2_set2_to_ascii u_lut (
        .code  (key_code),
        .shift (shift),
        .caps  (caps_lock),
        .ctrl  (ctrl),
        .ascii (lut_ascii),
        .hit   (lut_hit)
    );

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_req  = key_event & ~key_extended & ~key_release & lut_hit;
    assign full      = (count == CNT_FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push_ok   = push_req & (~full | pop);
    assign out_ascii = out_valid ? mem[rd_ptr] : 8'h00;

    // FIFO storage, written only on an accepted push
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= lut_ascii;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: expected events and characters are queued as bytes are sent.
module tb_ps2_key_decoder;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_error;
    logic       key_event;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;
    logic       shift;
    logic       ctrl;
    logic       caps_lock;
    logic [7:0] out_ascii;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] asc_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         pop_cnt = 0;
    logic       mon_en = 1'b0;

    ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_error     (in_error),
        .key_event    (key_event),
        .key_code     (key_code),
        .key_extended (key_extended),
        .key_release  (key_release),
        .shift        (shift),
        .ctrl         (ctrl),
        .caps_lock    (caps_lock),
        .out_ascii    (out_ascii),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge CLK); #1;
        in_data  = b;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic exp_ev(input logic [7:0] c, input logic e, input logic r);
        ev_t t;
        t.code = c;
        t.ext  = e;
        t.rel  = r;
        ev_q.push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drained(input string tag);
        idle(6);
        check({tag, "_ev_left"}, ev_q.size(), 0);
        check({tag, "_chr_left"}, asc_q.size(), 0);
    endtask

    // Monitor: compare every event and every accepted character against the queues
    always @(negedge CLK) begin
        if (mon_en) begin
            if (key_event) begin
                check("ev_pending", ev_q.size() != 0, 1);
                if (ev_q.size() != 0) begin
                    ev_t e;
                    e = ev_q.pop_front();
                    check("ev_code", key_code, e.code);
                    check("ev_ext", key_extended, e.ext);
                    check("ev_rel", key_release, e.rel);
                end
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                check("chr_pending", asc_q.size() != 0, 1);
                if (asc_q.size() != 0) check("chr_val", out_ascii, asc_q.pop_front());
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_error  = 1'b0;
        out_ready = 1'b1;
        idle(3);
        check("rst_event", key_event, 0);
        check("rst_code", key_code, 0);
        check("rst_shift", shift, 0);
        check("rst_ctrl", ctrl, 0);
        check("rst_caps", caps_lock, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ascii", out_ascii, 0);
        check("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(2);

        // Plain make/break of 'a'
        exp_ev(8'h1C, 0, 0); asc_q.push_back(8'h61); send(8'h1C);
        exp_ev(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
        check("a_shift", shift, 0);
        drained("a");

        // Shifted 'A'
        exp_ev(8'h12, 0, 0); send(8'h12);
        check("sh_held", shift, 1);
        exp_ev(8'h1C, 0, 0); asc_q.push_back(8'h41); send(8'h1C);
        exp_ev(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
        check("sh_mid", shift, 1);
        exp_ev(8'h12, 0, 1); send(8'hF0); send(8'h12);
        check("sh_off", shift, 0);
        drained("shift");

        // Caps lock with typematic repeat, then shift cancels caps
        exp_ev(8'h58, 0, 0); send(8'h58);
        exp_ev(8'h58, 0, 0); send(8'h58);
        exp_ev(8'h58, 0, 1); send(8'hF0); send(8'h58);
        check("caps_on", caps_lock, 1);
        exp_ev(8'h1C, 0, 0); asc_q.push_back(8'h41); send(8'h1C);
        exp_ev(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
        exp_ev(8'h12, 0, 0); send(8'h12);
        exp_ev(8'h1C, 0, 0); asc_q.push_back(8'h61); send(8'h1C);
        exp_ev(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
        exp_ev(8'h12, 0, 1); send(8'hF0); send(8'h12);
        exp_ev(8'h58, 0, 0); send(8'h58);
        exp_ev(8'h58, 0, 1); send(8'hF0); send(8'h58);
        check("caps_off", caps_lock, 0);
        drained("caps");

        // Ctrl folding: left ctrl + 'c' gives 0x03, right ctrl is extended
        exp_ev(8'h14, 0, 0); send(8'h14);
        check("lctrl_on", ctrl, 1);
        exp_ev(8'h21, 0, 0); asc_q.push_back(8'h03); send(8'h21);
        exp_ev(8'h21, 0, 1); send(8'hF0); send(8'h21);
        exp_ev(8'h14, 0, 1); send(8'hF0); send(8'h14);
        check("lctrl_off", ctrl, 0);
        exp_ev(8'h14, 1, 0); send(8'hE0); send(8'h14);
        check("rctrl_on", ctrl, 1);
        exp_ev(8'h14, 1, 1); send(8'hE0); send(8'hF0); send(8'h14);
        check("rctrl_off", ctrl, 0);
        drained("ctrl");

        // Extended arrow (no character), Pause sequence and a response byte (no events)
        exp_ev(8'h75, 1, 0); send(8'hE0); send(8'h75);
        exp_ev(8'h75, 1, 1); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'hFA);
        exp_ev(8'h1C, 0, 0); asc_q.push_back(8'h61); send(8'h1C);
        exp_ev(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
        drained("ext");

        // Overflow: five characters into a four-entry FIFO with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_ev(8'h1C, 0, 0); send(8'h1C);
            exp_ev(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
            if (i < 4) asc_q.push_back(8'h61);
        end
        idle(3);
        check("ovf_valid", out_valid, 1);
        check("ovf_head", out_ascii, 8'h61);
        check("ovf_flag", overflow, 1);
        pop_cnt   = 0;
        out_ready = 1'b1;
        idle(4);
        check("ovf_drain_valid", out_valid, 0);
        check("ovf_pops", pop_cnt, 4);
        drained("ovf");

        // Receiver error discards a pending F0
        exp_ev(8'h1C, 0, 0); asc_q.push_back(8'h61);
        send(8'hF0);
        @(posedge CLK); #1; in_error = 1'b1;
        @(posedge CLK); #1; in_error = 1'b0;
        send(8'h1C);
        exp_ev(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
        drained("err");

        // Reset with caps on and the FIFO half full
        exp_ev(8'h58, 0, 0); send(8'h58);
        exp_ev(8'h58, 0, 1); send(8'hF0); send(8'h58);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_ev(8'h1C, 0, 0); send(8'h1C);
            exp_ev(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
        end
        idle(3);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_caps", caps_lock, 1);
        check("pre_rst_ev_left", ev_q.size(), 0);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        idle(1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_caps", caps_lock, 0);
        check("mid_rst_ovf", overflow, 0);
        asc_q.delete();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        exp_ev(8'h1C, 0, 0); asc_q.push_back(8'h61); send(8'h1C);
        exp_ev(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
        drained("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
